// File: rtl/cache_miss_handler_if.sv
// rtl/cache_miss_handler_if.sv - cache-side and memory-side signal bundle for the miss handler
interface cache_miss_handler_if;
  logic         iMiss;
  logic [31:0]  iMissAddr;
  logic         iDirty;
  logic [31:0]  iVictimAddr;
  logic [127:0] iVictimLine;
  logic         oBusy;
  logic         oMemRd;
  logic         oMemWr;
  logic [31:0]  oMemAddr;
  logic [31:0]  oMemData;
  logic [31:0]  iMemData;
  logic         iMemAck;
  logic         oFillWr;
  logic [1:0]   oFillIdx;
  logic [31:0]  oFillData;
  logic         oDone;

  modport slave (
    input  iMiss, iMissAddr, iDirty, iVictimAddr, iVictimLine, iMemData, iMemAck,
    output oBusy, oMemRd, oMemWr, oMemAddr, oMemData, oFillWr, oFillIdx, oFillData, oDone
  );

  modport master (
    output iMiss, iMissAddr, iDirty, iVictimAddr, iVictimLine, iMemData, iMemAck,
    input  oBusy, oMemRd, oMemWr, oMemAddr, oMemData, oFillWr, oFillIdx, oFillData, oDone
  );
endinterface

// File: rtl/cache_miss_handler.sv
// rtl/cache_miss_handler.sv - victim write-back then line refill sequencer for one cache miss
module cache_miss_handler #(
  parameter int LINE_WORDS = 4
) (
  input logic                  clk,
  input logic                  reset,
  cache_miss_handler_if.slave  bus
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        fill_base;
  logic [31:0]        victim_base;
  logic [127:0]       victim_line;
  logic [31:0]        word_off;
  logic [31:0]        victim_word;
  logic               last_word;

  assign last_word   = (cnt == LAST_WORD);
  assign word_off    = 32'(cnt) << 2;
  assign victim_word = victim_line[{cnt, 5'b00000} +: 32];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; iMiss only matters in IDLE, iMemAck only in WB/FILL
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.iMiss) begin
          state_nx = bus.iDirty ? WB : FILL;
        end
      end
      WB: begin
        if (bus.iMemAck && last_word) begin
          state_nx = FILL;
        end
      end
      FILL: begin
        if (bus.iMemAck && last_word) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Captured request, word counter and registered refill write port.
  // cnt wraps from the last word back to 0, which clears it for the next phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      fill_base     <= '0;
      victim_base   <= '0;
      victim_line   <= '0;
      bus.oFillWr   <= 1'b0;
      bus.oFillIdx  <= '0;
      bus.oFillData <= '0;
    end else begin
      bus.oFillWr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iMiss) begin
            fill_base   <= bus.iMissAddr & LINE_MASK;
            victim_base <= bus.iVictimAddr & LINE_MASK;
            victim_line <= bus.iVictimLine;
            cnt         <= '0;
          end
        end
        WB: begin
          if (bus.iMemAck) begin
            cnt <= cnt + 1'b1;
          end
        end
        FILL: begin
          if (bus.iMemAck) begin
            bus.oFillWr   <= 1'b1;
            bus.oFillIdx  <= 2'(cnt);
            bus.oFillData <= bus.iMemData;
            cnt           <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: strobes, address and data are pure functions of state and cnt
  always_comb begin
    bus.oBusy    = (state != IDLE);
    bus.oDone    = (state == DONE);
    bus.oMemRd   = 1'b0;
    bus.oMemWr   = 1'b0;
    bus.oMemAddr = '0;
    bus.oMemData = '0;
    case (state)
      WB: begin
        bus.oMemWr   = 1'b1;
        bus.oMemAddr = victim_base + word_off;
        bus.oMemData = victim_word;
      end
      FILL: begin
        bus.oMemRd   = 1'b1;
        bus.oMemAddr = fill_base + word_off;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/cache_miss_handler.md
CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning the number of 32-bit words per cache line (fixed at 4 for this block).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port iMiss, input, 1, miss request from the cache, sampled only in IDLE.
REQ-005 SHALL have port iMissAddr, input, 32, the miss byte address.
REQ-006 SHALL have port iDirty, input, 1, victim-dirty flag.
REQ-007 SHALL have port iVictimAddr, input, 32, the victim line address.
REQ-008 SHALL have port iVictimLine, input, 128, victim data; word i occupies bits [32i+31:32i].
REQ-009 SHALL have port oBusy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have ports oMemRd and oMemWr, output, 1 each, memory read and write strobes.
REQ-011 SHALL have ports oMemAddr and oMemData, output, 32 each, memory word address and write data.
REQ-012 SHALL have ports iMemData, input, 32, and iMemAck, input, 1, memory read data and the per-word completion pulse.
REQ-013 SHALL have ports oFillWr, output, 1; oFillIdx, output, 2; and oFillData, output, 32, the cache refill word write.
REQ-014 SHALL have port oDone, output, 1, a one-cycle pulse marking refill complete.

Function
REQ-015 SHALL implement the FSM states IDLE, WB, FILL and DONE, with a 2-bit word counter cnt.
REQ-016 SHALL, in IDLE with iMiss=1:
- capture fill base = iMissAddr & 32'hFFFF_FFF0;
- capture victim base = iVictimAddr & 32'hFFFF_FFF0;
- capture iVictimLine;
- clear cnt;
- go to WB if iDirty=1, else go to FILL.
REQ-017 SHALL, in WB, drive oMemWr=1, oMemAddr = victim base + 4*cnt and oMemData = captured word cnt, held stable until iMemAck.
REQ-018 SHALL, on iMemAck in WB, increment cnt; after the ack with cnt=3 it SHALL clear cnt and go to FILL.
REQ-019 SHALL, in FILL, drive oMemRd=1 and oMemAddr = fill base + 4*cnt, held until iMemAck.
REQ-020 SHALL, on iMemAck in FILL, register oFillData<=iMemData, oFillIdx<=cnt and oFillWr<=1 for exactly one cycle, then increment cnt.
REQ-021 SHALL go from FILL to DONE on the ack with cnt=3, assert oDone=1 for one cycle in DONE (coincident with the last oFillWr), and return to IDLE.
REQ-022 SHALL never assert oMemRd and oMemWr in the same cycle.
REQ-023 SHALL drive oMemRd=0 and oMemWr=0 in IDLE and DONE.
REQ-024 SHALL ignore iMiss whenever the state is not IDLE; there is no queueing.
REQ-025 SHALL ignore iMemAck in IDLE and DONE.
REQ-026 SHALL accept a new iMiss in the first IDLE cycle after DONE, giving back-to-back misses with a one-cycle gap.
REQ-027 SHALL let an ack in the same cycle the strobe is first asserted complete that word, giving a minimum of 1 cycle per word.
REQ-028 SHALL compute address arithmetic modulo 2^32; a line base of FFFF_FFF0 wraps no further, because cnt is at most 3.
REQ-029 SHALL keep oMemAddr and oMemData at 0 when no strobe is active.

Reset
REQ-030 SHALL, with reset=1 at a rising edge:
- set the state to IDLE and cnt to 0;
- set oBusy, oMemRd, oMemWr, oFillWr and oDone to 0;
- set oFillIdx to 0, oFillData to 0, and the captured address and line registers to 0.
REQ-031 SHALL, on reset mid-WB or mid-FILL, abort the transfer without completing it and deassert the strobes from the next cycle, with no oDone.
REQ-032 SHALL give reset priority over iMiss and iMemAck in the same cycle.

Verification
REQ-033 SHALL cover a clean miss: iMiss with iMissAddr=FDEF_1004, iDirty=0, and memory acking one cycle after each strobe with data 1000_0000+i.
- Required: 4 reads at FDEF_1000, FDEF_1004, FDEF_1008 and FDEF_100C.
- Required: oFillWr idx 0..3 with the matching data, then oDone.
- Required: no oMemWr.
REQ-034 SHALL cover a dirty miss: iDirty=1, iVictimAddr=1234_5670, iVictimLine={D3,D2,D1,D0}.
- Required: 4 writes at 1234_5670..1234_567C carrying D0..D3, then 4 fill reads, then oDone.
- Required: oBusy high for the whole sequence.
REQ-035 SHALL cover zero-wait memory: iMemAck held at 1.
- Required for a clean miss: oDone 6 cycles after iMiss is sampled.
- Required for a dirty miss: oDone 10 cycles after iMiss is sampled.
REQ-036 SHALL cover a miss while busy: a second iMiss (addr 0000_0040) during FILL is ignored, and only the first line is filled.
REQ-037 SHALL cover reset after the second FILL ack.
- Required: the next cycle shows oBusy=0, oMemRd=0 and no oDone.
- Required: a new miss then completes normally.
REQ-038 SHALL cover an address boundary: iMissAddr=FFFF_FFFC gives fill reads at FFFF_FFF0..FFFF_FFFC.
